// File: rtl/prco_reg_port_pkg.sv
// prco_reg_port_pkg: shared constants for the PRCO register-set port.
//   DATA_W_DEF / SEL_W_DEF : default data and select widths
//   REG_SP / REG_BP        : stack/base pointer register indices
//   state_e                : operand-fetch FSM encoding
package prco_reg_port_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int SEL_W_DEF  = 3;
  localparam int REG_SP     = 6;
  localparam int REG_BP     = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_e;
endpackage

// File: rtl/prco_reg_port_if.sv
// prco_reg_port_if: request, operand, writeback and register-set signals.
//   slave  : the port block (consumes i_*, drives q_*)
//   master : the surrounding environment (drives i_*, consumes q_*)
interface prco_reg_port_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic              i_req_valid;
  logic              q_req_ready;
  logic [SEL_W-1:0]  i_req_sela;
  logic [SEL_W-1:0]  i_req_selb;
  logic              i_req_wen;
  logic [SEL_W-1:0]  i_req_wdst;
  logic              q_op_valid;
  logic              i_op_ready;
  logic [DATA_W-1:0] q_op_a;
  logic [DATA_W-1:0] q_op_b;
  logic              i_wb_valid;
  logic [SEL_W-1:0]  i_wb_sel;
  logic [DATA_W-1:0] i_wb_data;
  logic              q_rf_en;
  logic              q_rf_reset;
  logic [SEL_W-1:0]  q_rf_sela;
  logic [SEL_W-1:0]  q_rf_selb;
  logic [DATA_W-1:0] i_rf_data;
  logic [DATA_W-1:0] i_rf_datb;
  logic              q_rf_we;
  logic [SEL_W-1:0]  q_rf_seld;
  logic [DATA_W-1:0] q_rf_datd;

  modport slave (
    input  i_req_valid, i_req_sela, i_req_selb, i_req_wen, i_req_wdst,
           i_op_ready, i_wb_valid, i_wb_sel, i_wb_data, i_rf_data, i_rf_datb,
    output q_req_ready, q_op_valid, q_op_a, q_op_b, q_rf_en, q_rf_reset,
           q_rf_sela, q_rf_selb, q_rf_we, q_rf_seld, q_rf_datd
  );

  modport master (
    output i_req_valid, i_req_sela, i_req_selb, i_req_wen, i_req_wdst,
           i_op_ready, i_wb_valid, i_wb_sel, i_wb_data, i_rf_data, i_rf_datb,
    input  q_req_ready, q_op_valid, q_op_a, q_op_b, q_rf_en, q_rf_reset,
           q_rf_sela, q_rf_selb, q_rf_we, q_rf_seld, q_rf_datd
  );
endinterface

// File: rtl/prco_reg_port_scoreboard.sv
// prco_scoreboard: one pending bit per register.
//   i_clk, i_reset_n     : clock, synchronous active-low reset
//   i_set_en/i_set_sel   : mark a destination pending
//   i_clr_en/i_clr_sel   : retire a destination (writeback)
//   i_look_a/b, q_pend_a/b : combinational lookups of the current bits
module prco_scoreboard #(
  parameter int SEL_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_set_en,
  input  logic [SEL_W-1:0] i_set_sel,
  input  logic             i_clr_en,
  input  logic [SEL_W-1:0] i_clr_sel,
  input  logic [SEL_W-1:0] i_look_a,
  input  logic [SEL_W-1:0] i_look_b,
  output logic             q_pend_a,
  output logic             q_pend_b
);
  localparam int N = 1 << SEL_W;

  logic [N-1:0] sb_q, sb_d;

  // Set is applied after clear so a new owner stays pending when the old
  // owner retires on the same edge.
  always_comb begin
    sb_d = sb_q;
    if (i_clr_en) sb_d[i_clr_sel] = 1'b0;
    if (i_set_en) sb_d[i_set_sel] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) sb_q <= '0;
    else            sb_q <= sb_d;
  end

  assign q_pend_a = sb_q[i_look_a];
  assign q_pend_b = sb_q[i_look_b];
endmodule

// File: rtl/prco_reg_port.sv
// prco_reg_port: initiator side of the PRCO register-set interface.
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   bus (slave)      : request/operand handshake, writeback strobe and the
//                      register-set select/data/write ports
// One fetch in flight: IDLE (accept) -> READ (set samples selects) ->
// CAPT (capture data) -> RESP (hold until consumer takes operands).
module prco_reg_port
  import prco_reg_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter bit SB_EN  = 1'b1
) (
  input logic            i_clk,
  input logic            i_reset_n,
  prco_reg_port_if.slave bus
);
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sela_q, sela_d, selb_q, selb_d;
  logic [DATA_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic              fwd_a_v_q, fwd_a_v_d, fwd_b_v_q, fwd_b_v_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              op_valid_q, op_valid_d;
  logic              rf_reset_q;
  logic              pend_a, pend_b, hazard, req_ready, accept;

  prco_scoreboard #(.SEL_W(SEL_W)) u_sb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_set_en  (accept && bus.i_req_wen),
    .i_set_sel (bus.i_req_wdst),
    .i_clr_en  (bus.i_wb_valid),
    .i_clr_sel (bus.i_wb_sel),
    .i_look_a  (bus.i_req_sela),
    .i_look_b  (bus.i_req_selb),
    .q_pend_a  (pend_a),
    .q_pend_b  (pend_b)
  );

  // A pending source being written back this cycle is not a hazard: the
  // write lands before the READ-cycle sample edge.
  assign hazard = SB_EN &&
    ((pend_a && !(bus.i_wb_valid && bus.i_wb_sel == bus.i_req_sela)) ||
     (pend_b && !(bus.i_wb_valid && bus.i_wb_sel == bus.i_req_selb)));
  assign req_ready = (state_q == ST_IDLE) && !hazard;
  assign accept    = bus.i_req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    sela_d     = sela_q;
    selb_d     = selb_q;
    fwd_a_d    = fwd_a_q;
    fwd_b_d    = fwd_b_q;
    fwd_a_v_d  = fwd_a_v_q;
    fwd_b_v_d  = fwd_b_v_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        sela_d  = bus.i_req_sela;
        selb_d  = bus.i_req_selb;
        state_d = ST_READ;
      end
      ST_READ: begin
        // A write on the sample edge returns the old value; keep the new one.
        if (bus.i_wb_valid && bus.i_wb_sel == sela_q) begin
          fwd_a_d   = bus.i_wb_data;
          fwd_a_v_d = 1'b1;
        end
        if (bus.i_wb_valid && bus.i_wb_sel == selb_q) begin
          fwd_b_d   = bus.i_wb_data;
          fwd_b_v_d = 1'b1;
        end
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        op_a_d     = fwd_a_v_q ? fwd_a_q : bus.i_rf_data;
        op_b_d     = fwd_b_v_q ? fwd_b_q : bus.i_rf_datb;
        op_valid_d = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: if (bus.i_op_ready) begin
        op_valid_d = 1'b0;
        fwd_a_v_d  = 1'b0;
        fwd_b_v_d  = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      sela_q     <= '0;
      selb_q     <= '0;
      fwd_a_q    <= '0;
      fwd_b_q    <= '0;
      fwd_a_v_q  <= 1'b0;
      fwd_b_v_q  <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      rf_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sela_q     <= sela_d;
      selb_q     <= selb_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      fwd_a_v_q  <= fwd_a_v_d;
      fwd_b_v_q  <= fwd_b_v_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      rf_reset_q <= 1'b0;
    end
  end

  assign bus.q_req_ready = req_ready;
  assign bus.q_op_valid  = op_valid_q;
  assign bus.q_op_a      = op_a_q;
  assign bus.q_op_b      = op_b_q;
  assign bus.q_rf_en     = 1'b1;
  assign bus.q_rf_reset  = rf_reset_q;
  assign bus.q_rf_sela   = sela_q;
  assign bus.q_rf_selb   = selb_q;
  assign bus.q_rf_we     = bus.i_wb_valid && i_reset_n;
  assign bus.q_rf_seld   = bus.i_wb_sel;
  assign bus.q_rf_datd   = bus.i_wb_data;
endmodule

// File: tb/tb_prco_reg_port.sv
module tb_prco_reg_port;
  import prco_reg_port_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  prco_reg_port_if #(.DATA_W(16), .SEL_W(3)) bus ();

  prco_reg_port #(.DATA_W(16), .SEL_W(3), .SB_EN(1'b1)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // Register-set model: reset loads SP/BP with 16'h00FF, write commits at
  // the edge, read data is registered from the selects (old value on a
  // same-edge write).
  logic [15:0] regs [8];
  always @(posedge clk) begin
    if (bus.q_rf_reset === 1'b1) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      regs[REG_SP] <= 16'h00FF;
      regs[REG_BP] <= 16'h00FF;
    end else if (bus.q_rf_we === 1'b1) begin
      regs[bus.q_rf_seld] <= bus.q_rf_datd;
    end
    if (bus.q_rf_en === 1'b1) begin
      bus.i_rf_data <= regs[bus.q_rf_sela];
      bus.i_rf_datb <= regs[bus.q_rf_selb];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Single writeback cycle; checks the combinational pass-through.
  task automatic wb(input logic [2:0] s, input logic [15:0] d);
    bus.i_wb_valid = 1'b1; bus.i_wb_sel = s; bus.i_wb_data = d;
    #1;
    chk("wb_we", bus.q_rf_we, 1);
    chk("wb_seld", bus.q_rf_seld, s);
    chk("wb_datd", bus.q_rf_datd, d);
    @(posedge clk); #1;
    bus.i_wb_valid = 1'b0;
  endtask

  // Issue a fetch; optional writeback in the accept cycle (aw_*) and in the
  // READ cycle (rw_*). Returns with q_op_valid expected high.
  task automatic issue(input logic [2:0] sa, input logic [2:0] sb, input logic wen,
                       input logic [2:0] wd, input logic aw_v, input logic [2:0] aw_s,
                       input logic [15:0] aw_d, input logic rw_v, input logic [2:0] rw_s,
                       input logic [15:0] rw_d, output int waits);
    int lat;
    bus.i_req_valid = 1'b1; bus.i_req_sela = sa; bus.i_req_selb = sb;
    bus.i_req_wen = wen; bus.i_req_wdst = wd;
    bus.i_wb_valid = aw_v; bus.i_wb_sel = aw_s; bus.i_wb_data = aw_d;
    #1;
    waits = 0;
    while (bus.q_req_ready !== 1'b1) begin
      if (waits == 50) begin
        chk("accept_timeout", 0, 1);
        bus.i_req_valid = 1'b0; bus.i_wb_valid = 1'b0;
        return;
      end
      @(posedge clk); #2;
      waits++;
    end
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0; bus.i_req_wen = 1'b0;
    bus.i_wb_valid = rw_v; bus.i_wb_sel = rw_s; bus.i_wb_data = rw_d;
    @(posedge clk); #1;
    bus.i_wb_valid = 1'b0;
    lat = 2;
    while (bus.q_op_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3);
  endtask

  task automatic take(input string nm, input logic [15:0] ea, input logic [15:0] eb);
    chk({nm, "_a"}, bus.q_op_a, ea);
    chk({nm, "_b"}, bus.q_op_b, eb);
    chk({nm, "_busy"}, bus.q_req_ready, 0);
    bus.i_op_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_op_ready = 1'b0;
    chk({nm, "_vclr"}, bus.q_op_valid, 0);
  endtask

  typedef struct {
    logic        do_wb;
    logic [2:0]  wb_sel;
    logic [15:0] wb_data;
    logic [2:0]  sa, sb;
    logic        wen;
    logic [2:0]  wd;
    logic [15:0] ea, eb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int w;
    vecs[0] = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd7, 1'b0, 3'd0, 16'h00FF, 16'h00FF};
    vecs[1] = '{1'b1, 3'd1, 16'h1234, 3'd1, 3'd0, 1'b0, 3'd0, 16'h1234, 16'h0000};
    vecs[2] = '{1'b1, 3'd4, 16'hA5A5, 3'd4, 3'd4, 1'b0, 3'd0, 16'hA5A5, 16'hA5A5};
    vecs[3] = '{1'b1, 3'd5, 16'h0F0F, 3'd5, 3'd1, 1'b1, 3'd5, 16'h0F0F, 16'h1234};
    vecs[4] = '{1'b1, 3'd5, 16'h7777, 3'd5, 3'd6, 1'b0, 3'd0, 16'h7777, 16'h00FF};
    vecs[5] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd4, 1'b0, 3'd0, 16'hFFFF, 16'hA5A5};

    rst_n = 1'b0;
    bus.i_req_valid = 1'b0; bus.i_req_sela = '0; bus.i_req_selb = '0;
    bus.i_req_wen = 1'b0; bus.i_req_wdst = '0; bus.i_op_ready = 1'b0;
    bus.i_wb_valid = 1'b0; bus.i_wb_sel = '0; bus.i_wb_data = '0;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_valid", bus.q_op_valid, 0);
    chk("rst_rf_reset", bus.q_rf_reset, 1);
    chk("rst_rf_en", bus.q_rf_en, 1);
    chk("rst_op_a", bus.q_op_a, 0);
    chk("rst_rf_sela", bus.q_rf_sela, 0);
    bus.i_wb_valid = 1'b1;
    #1;
    chk("rst_we_gated", bus.q_rf_we, 0);
    bus.i_wb_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rf_reset_drop", bus.q_rf_reset, 0);

    // Table-driven fetches.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_wb) wb(vecs[i].wb_sel, vecs[i].wb_data);
      issue(vecs[i].sa, vecs[i].sb, vecs[i].wen, vecs[i].wd,
            1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, w);
      take($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb);
    end

    // RAW stall: r2 pending until its writeback, accepted in that cycle.
    issue(3'd0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, w);
    take("raw_own", 16'hFFFF, 16'hFFFF);
    bus.i_req_valid = 1'b1; bus.i_req_sela = 3'd2; bus.i_req_selb = 3'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("raw_stall", bus.q_req_ready, 0);
      @(posedge clk); #1;
    end
    issue(3'd2, 3'd1, 1'b0, 3'd0, 1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0, 16'h0, w);
    chk("raw_wb_accept", w, 0);
    take("raw", 16'hBEEF, 16'h1234);

    // Set and clear of r4 on one edge: the new owner stays pending.
    issue(3'd0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0, w);
    take("setwin_own", 16'hFFFF, 16'hFFFF);
    bus.i_req_valid = 1'b1; bus.i_req_sela = 3'd4; bus.i_req_selb = 3'd0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("setwin_stall", bus.q_req_ready, 0);
      @(posedge clk); #1;
    end
    issue(3'd4, 3'd0, 1'b0, 3'd0, 1'b1, 3'd4, 16'h4545, 1'b0, 3'd0, 16'h0, w);
    take("setwin", 16'h4545, 16'hFFFF);

    // Writeback on the READ sample edge is forwarded to both operands.
    issue(3'd3, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'hCAFE, w);
    take("fwd", 16'hCAFE, 16'hCAFE);
    issue(3'd3, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, w);
    take("fwd_commit", 16'hCAFE, 16'hBEEF);

    // Backpressure for 5 cycles with a writeback in the middle.
    issue(3'd1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, w);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus.i_wb_valid = 1'b1; bus.i_wb_sel = 3'd6; bus.i_wb_data = 16'h6666;
      end
      #1;
      chk("bp_a", bus.q_op_a, 16'h1234);
      chk("bp_b", bus.q_op_b, 16'h7777);
      chk("bp_valid", bus.q_op_valid, 1);
      chk("bp_ready", bus.q_req_ready, 0);
      @(posedge clk); #1;
      bus.i_wb_valid = 1'b0;
    end
    take("bp", 16'h1234, 16'h7777);
    issue(3'd6, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, w);
    take("bp_wb_kept", 16'h6666, 16'h6666);

    // Reset while in CAPT: no operands, scoreboard cleared.
    bus.i_req_valid = 1'b1; bus.i_req_sela = 3'd6; bus.i_req_selb = 3'd7;
    bus.i_req_wen = 1'b1; bus.i_req_wdst = 3'd3;
    #1;
    chk("mr_ready", bus.q_req_ready, 1);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0; bus.i_req_wen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mr_op_valid", bus.q_op_valid, 0);
    chk("mr_rf_reset", bus.q_rf_reset, 1);
    rst_n = 1'b1;
    issue(3'd3, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, w);
    chk("mr_immediate", w, 0);
    take("mr", 16'h0000, 16'h00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
